// File: rtl/execute.sv
// RISC-V execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EXECUTE_MUL_EN to add the 4-cycle byte-serial multiplier (ALUControlE=110).
module execute (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] ImmExtE,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        StallE,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM
);
  logic [31:0] src_a, write_data_e, src_b, alu_result;
  logic        zero_e;

  // Source indices only matter to the hazard unit.
  logic unused_idx;
  assign unused_idx = ^{Rs1E, Rs2E};

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALUResultM;
      default: write_data_e = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : write_data_e;
  end

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'b0;
    endcase
  end

  assign zero_e    = (alu_result == 32'b0);
  assign PCSrcE    = JumpE | (BranchE & zero_e);
  assign PCTargetE = PCE + ImmExtE;

  logic [31:0] alu_m_d, alu_m_q, wd_m_d, wd_m_q, pc4_m_d, pc4_m_q;
  logic [4:0]  rd_m_d, rd_m_q;
  logic        rw_m_d, rw_m_q, mw_m_d, mw_m_q;
  logic [1:0]  rs_m_d, rs_m_q;
  logic        stall, mul_done;
  logic [31:0] mul_result;

`ifdef EXECUTE_MUL_EN
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_d, state_q;
  logic [1:0]  cnt_d, cnt_q;
  logic [31:0] acc_d, acc_q, ma_d, ma_q, mb_d, mb_q, wd_c_d, wd_c_q, pc4_c_d, pc4_c_q;
  logic [4:0]  rd_c_d, rd_c_q;
  logic        rw_c_d, rw_c_q, mw_c_d, mw_c_q;
  logic [1:0]  rs_c_d, rs_c_q;
  logic [31:0] b_shift, partial;

  // One 32x8 partial product per RUN cycle, aligned to the byte being consumed.
  assign b_shift    = mb_q >> {cnt_q, 3'b000};
  assign partial    = (ma_q * {24'b0, b_shift[7:0]}) << {cnt_q, 3'b000};
  assign mul_result = acc_q + partial;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  acc_d = acc_q;
    ma_d = ma_q;  mb_d = mb_q;  wd_c_d = wd_c_q;  pc4_c_d = pc4_c_q;
    rd_c_d = rd_c_q;  rw_c_d = rw_c_q;  mw_c_d = mw_c_q;  rs_c_d = rs_c_q;
    stall = 1'b0;  mul_done = 1'b0;
    case (state_q)
      IDLE: if (ALUControlE == 3'b110) begin
        stall = 1'b1;
        ma_d = src_a;  mb_d = src_b;  wd_c_d = write_data_e;  pc4_c_d = PCPlus4E;
        rd_c_d = RdE;  rw_c_d = RegWriteE;  mw_c_d = MemWriteE;  rs_c_d = ResultSrcE;
        acc_d = 32'b0;  cnt_d = 2'd0;  state_d = RUN;
      end
      RUN: begin
        acc_d = mul_result;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;  cnt_q <= 2'd0;  acc_q <= 32'b0;
      ma_q <= 32'b0;  mb_q <= 32'b0;  wd_c_q <= 32'b0;  pc4_c_q <= 32'b0;
      rd_c_q <= 5'b0;  rw_c_q <= 1'b0;  mw_c_q <= 1'b0;  rs_c_q <= 2'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  acc_q <= acc_d;
      ma_q <= ma_d;  mb_q <= mb_d;  wd_c_q <= wd_c_d;  pc4_c_q <= pc4_c_d;
      rd_c_q <= rd_c_d;  rw_c_q <= rw_c_d;  mw_c_q <= mw_c_d;  rs_c_q <= rs_c_d;
    end
  end
`else
  assign stall      = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = 32'b0;
`endif

  assign StallE = stall;

  always_comb begin
    alu_m_d = alu_result;  wd_m_d = write_data_e;  pc4_m_d = PCPlus4E;
    rd_m_d = RdE;  rw_m_d = RegWriteE;  mw_m_d = MemWriteE;  rs_m_d = ResultSrcE;
    if (stall) begin
      alu_m_d = 32'b0;  wd_m_d = 32'b0;  pc4_m_d = 32'b0;
      rd_m_d = 5'b0;  rw_m_d = 1'b0;  mw_m_d = 1'b0;  rs_m_d = 2'b0;
    end else if (mul_done) begin
`ifdef EXECUTE_MUL_EN
      alu_m_d = mul_result;  wd_m_d = wd_c_q;  pc4_m_d = pc4_c_q;
      rd_m_d = rd_c_q;  rw_m_d = rw_c_q;  mw_m_d = mw_c_q;  rs_m_d = rs_c_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_m_q <= 32'b0;  wd_m_q <= 32'b0;  pc4_m_q <= 32'b0;
      rd_m_q <= 5'b0;  rw_m_q <= 1'b0;  mw_m_q <= 1'b0;  rs_m_q <= 2'b0;
    end else begin
      alu_m_q <= alu_m_d;  wd_m_q <= wd_m_d;  pc4_m_q <= pc4_m_d;
      rd_m_q <= rd_m_d;  rw_m_q <= rw_m_d;  mw_m_q <= mw_m_d;  rs_m_q <= rs_m_d;
    end
  end

  assign ALUResultM = alu_m_q;
  assign WriteDataM = wd_m_q;
  assign PCPlus4M   = pc4_m_q;
  assign RdM        = rd_m_q;
  assign RegWriteM  = rw_m_q;
  assign MemWriteM  = mw_m_q;
  assign ResultSrcM = rs_m_q;
endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage; mul checks follow the EXECUTE_MUL_EN build.
module tb_execute;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;

  int n_vec = 0;
  int n_err = 0;

  execute dut (
    .clk(clk), .reset(reset), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallE(StallE), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, ".alu"}, ALUResultM, 32'h0);
    chk({tag, ".wd"},  WriteDataM, 32'h0);
    chk({tag, ".pc4"}, PCPlus4M, 32'h0);
    chk({tag, ".ctl"}, {22'b0, RdM, RegWriteM, MemWriteM, ResultSrcM}, 32'h0);
  endtask

  initial begin
    // arbitrary non-zero inputs while in reset
    reset = 1'b0;  RD1E = 32'hA5A5_0001;  RD2E = 32'h0000_0F0F;  PCE = 32'h400;
    PCPlus4E = 32'h404;  ImmExtE = 32'h10;  ResultW = 32'h77;  Rs1E = 5'd1;  Rs2E = 5'd2;
    RdE = 5'd9;  RegWriteE = 1'b1;  MemWriteE = 1'b1;  JumpE = 1'b0;  BranchE = 1'b0;
    ALUSrcE = 1'b0;  ResultSrcE = 2'b11;  ALUControlE = 3'b011;  ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    tick();  tick();
    chk_m_zero("reset");
    chk("reset.stall", {31'b0, StallE}, 32'h0);

    // add 5+7
    reset = 1'b1;  RD1E = 32'd5;  RD2E = 32'd7;  ALUControlE = 3'b000;  RdE = 5'd3;
    RegWriteE = 1'b1;  MemWriteE = 1'b0;  ResultSrcE = 2'b10;  PCPlus4E = 32'h104;
    tick();
    chk("add.alu", ALUResultM, 32'd12);
    chk("add.wd",  WriteDataM, 32'd7);
    chk("add.ctl", {22'b0, RdM, RegWriteM, MemWriteM, ResultSrcM}, {22'b0, 5'd3, 1'b1, 1'b0, 2'b10});
    chk("add.pc4", PCPlus4M, 32'h104);

    // produce 100 in EX/MEM, then forward it
    RD1E = 32'd60;  RD2E = 32'd40;
    tick();
    chk("fwd.setup", ALUResultM, 32'd100);
    ForwardAE = 2'b10;  ALUSrcE = 1'b1;  ImmExtE = 32'hFFFF_FFFC;
    ForwardBE = 2'b01;  ResultW = 32'h0000_DEAD;
    tick();
    chk("fwd.alu", ALUResultM, 32'd96);
    chk("fwd.wd",  WriteDataM, 32'h0000_DEAD);

    // ForwardAE=11 selects the register file; sub
    ForwardAE = 2'b11;  ForwardBE = 2'b00;  ALUSrcE = 1'b0;  ALUControlE = 3'b001;
    RD1E = 32'd9;  RD2E = 32'd4;
    tick();
    chk("sub", ALUResultM, 32'd5);

    // branch resolution (combinational)
    ForwardAE = 2'b00;  BranchE = 1'b1;  RD1E = 32'd42;  RD2E = 32'd42;
    PCE = 32'h1000;  ImmExtE = 32'h20;
    #1;
    chk("beq.taken", {31'b0, PCSrcE}, 32'h1);
    chk("beq.tgt", PCTargetE, 32'h1020);
    RD2E = 32'd43;
    #1;
    chk("beq.ntaken", {31'b0, PCSrcE}, 32'h0);
    JumpE = 1'b1;
    #1;
    chk("jump", {31'b0, PCSrcE}, 32'h1);
    JumpE = 1'b0;  BranchE = 1'b0;

    // slt / and / or / undefined
    ALUControlE = 3'b101;  RD1E = 32'hFFFF_FFFF;  RD2E = 32'd1;
    tick();
    chk("slt.neg", ALUResultM, 32'd1);
    RD1E = 32'd1;  RD2E = 32'hFFFF_FFFF;
    tick();
    chk("slt.pos", ALUResultM, 32'd0);
    ALUControlE = 3'b010;  RD1E = 32'h0000_F0F0;  RD2E = 32'h0000_FF00;
    tick();
    chk("and", ALUResultM, 32'h0000_F000);
    ALUControlE = 3'b011;
    tick();
    chk("or", ALUResultM, 32'h0000_FFF0);
    ALUControlE = 3'b111;
    tick();
    chk("undef", ALUResultM, 32'h0);

    // mul 0x12345678 * 0x9ABCDEF0
    ALUControlE = 3'b110;  RD1E = 32'h1234_5678;  RD2E = 32'h9ABC_DEF0;  RdE = 5'd7;
    RegWriteE = 1'b1;  ResultSrcE = 2'b00;
    #1;
`ifdef EXECUTE_MUL_EN
    chk("mul.stall0", {31'b0, StallE}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) begin
        ResultW = 32'hFFFF_FFFF;  RD1E = 32'h1;  // captured operands must not change
      end
      chk("mul.bubble.rw", {31'b0, RegWriteM}, 32'h0);
      chk("mul.bubble.alu", ALUResultM, 32'h0);
      chk("mul.stall", {31'b0, StallE}, (i < 4) ? 32'h1 : 32'h0);
    end
    tick();
    chk("mul.result", ALUResultM, 32'h242D_2080);
    chk("mul.ctl", {22'b0, RdM, RegWriteM, MemWriteM, ResultSrcM}, {22'b0, 5'd7, 1'b1, 1'b0, 2'b00});
    ALUControlE = 3'b000;  RD1E = 32'h0;  RD2E = 32'h0;
    #1;
    chk("mul.idle", {31'b0, StallE}, 32'h0);
    tick();

    // abort in the 2nd RUN cycle
    ALUControlE = 3'b110;  RD1E = 32'h1234_5678;  RD2E = 32'h9ABC_DEF0;
    tick();  tick();
    reset = 1'b0;  ALUControlE = 3'b000;  RD1E = 32'h0;  RD2E = 32'h0;
    tick();
    chk_m_zero("abort");
    chk("abort.stall", {31'b0, StallE}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort.noprod", ALUResultM, 32'h0);
    end
`else
    chk("mul.nostall", {31'b0, StallE}, 32'h0);
    tick();
    chk("mul.undef", ALUResultM, 32'h0);
    chk("mul.rw", {31'b0, RegWriteM}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
